// File: rtl/chunk_add_sequencer.sv
// Wide adder sequencer: feeds one CHUNK-bit shared adder one chunk per clock, LSB first.
// Optional macro CHUNK_ADD_SUB_EN adds an iSub port for two's-complement subtraction.
module chunk_add_sequencer #(
    parameter int CHUNK  = 10,
    parameter int NCHUNK = 4
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic                    iStart,
    input  logic [CHUNK*NCHUNK-1:0] iA,
    input  logic [CHUNK*NCHUNK-1:0] iB,
    input  logic                    iCarry,
`ifdef CHUNK_ADD_SUB_EN
    input  logic                    iSub,
`endif
    output logic                    oReady,
    output logic                    oValid,
    input  logic                    iAck,
    output logic [CHUNK*NCHUNK-1:0] oRes,
    output logic                    oCarry,
    output logic [CHUNK-1:0]        oAdA,
    output logic [CHUNK-1:0]        oAdB,
    output logic                    oAdCin,
    input  logic [CHUNK-1:0]        iAdRes,
    input  logic                    iAdCout
);

    localparam int W  = CHUNK * NCHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    res_acc;
    logic [W-1:0]    res_next;
    logic            carry_reg;
    logic            init_carry;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;

    assign a_chunk = a_reg[cnt*CHUNK +: CHUNK];

`ifdef CHUNK_ADD_SUB_EN
    logic sub_reg;

    // Subtraction is A + ~B + 1, so the chain starts with a forced carry.
    assign b_chunk    = sub_reg ? ~b_reg[cnt*CHUNK +: CHUNK] : b_reg[cnt*CHUNK +: CHUNK];
    assign init_carry = iSub ? 1'b1 : iCarry;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sub_reg <= 1'b0;
        end else if (state == IDLE && iStart) begin
            sub_reg <= iSub;
        end
    end
`else
    assign b_chunk    = b_reg[cnt*CHUNK +: CHUNK];
    assign init_carry = iCarry;
`endif

    always_comb begin
        res_next = res_acc;
        res_next[cnt*CHUNK +: CHUNK] = iAdRes;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The shared adder inputs stay at zero outside RUN so other users can share it cleanly.
    always_comb begin
        state_next = state;
        oReady     = 1'b0;
        oValid     = 1'b0;
        oAdA       = '0;
        oAdB       = '0;
        oAdCin     = 1'b0;
        case (state)
            IDLE: begin
                oReady = 1'b1;
                if (iStart) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                oAdA   = a_chunk;
                oAdB   = b_chunk;
                oAdCin = carry_reg;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                oValid = 1'b1;
                if (iAck) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_acc   <= '0;
            carry_reg <= 1'b0;
            oRes      <= '0;
            oCarry    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        a_reg     <= iA;
                        b_reg     <= iB;
                        carry_reg <= init_carry;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    res_acc   <= res_next;
                    carry_reg <= iAdCout;
                    if (cnt == LAST) begin
                        oRes   <= res_next;
                        oCarry <= iAdCout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_add_sequencer.sv
// Directed testbench for chunk_add_sequencer with a behavioural model of the shared adder.
// Define CHUNK_ADD_SUB_EN to also exercise the subtract option.
module tb_chunk_add_sequencer;

    localparam int CHUNK  = 10;
    localparam int NCHUNK = 4;
    localparam int W      = CHUNK * NCHUNK;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             carry_in;
    logic             sub;
    logic             ready;
    logic             valid;
    logic             ack;
    logic [W-1:0]     res;
    logic             carry_out;
    logic [CHUNK-1:0] ad_a;
    logic [CHUNK-1:0] ad_b;
    logic             ad_cin;
    logic [CHUNK-1:0] ad_res;
    logic             ad_cout;

    int errors = 0;
    int checks = 0;
    int n;

    chunk_add_sequencer #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iStart  (start),
        .iA      (a),
        .iB      (b),
        .iCarry  (carry_in),
`ifdef CHUNK_ADD_SUB_EN
        .iSub    (sub),
`endif
        .oReady  (ready),
        .oValid  (valid),
        .iAck    (ack),
        .oRes    (res),
        .oCarry  (carry_out),
        .oAdA    (ad_a),
        .oAdB    (ad_b),
        .oAdCin  (ad_cin),
        .iAdRes  (ad_res),
        .iAdCout (ad_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared combinational adder
    always_comb {ad_cout, ad_res} = {1'b0, ad_a} + {1'b0, ad_b} + {{CHUNK{1'b0}}, ad_cin};

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents an operation and leaves the bench at the negedge of RUN chunk 0 (n=1).
    task automatic apply_stimulus(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                  input logic op_c, input logic op_s);
        a        = op_a;
        b        = op_b;
        carry_in = op_c;
        sub      = op_s;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
    endtask

    task automatic wait_valid(input string tag);
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 64'(n), 64'd5);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        ack      = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        sub      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("reset_ready", 64'(ready), 64'd1);
        check_output("reset_valid", 64'(valid), 64'd0);
        check_output("reset_res", 64'(res), 64'd0);
        check_output("reset_ad", {ad_a, ad_b, ad_cin}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_ready", 64'(ready), 64'd1);

        // Carry ripples out of chunk 0 into chunk 1
        apply_stimulus(40'h00_0000_03FF, 40'h1, 1'b0, 1'b0);
        check_output("k0_ad_a", 64'(ad_a), 64'h3FF);
        check_output("k0_ad_b", 64'(ad_b), 64'h1);
        check_output("k0_ad_cin", 64'(ad_cin), 64'd0);
        check_output("k0_ready", 64'(ready), 64'd0);
        @(negedge clk);
        n++;
        check_output("k1_ad_cin", 64'(ad_cin), 64'd1);
        check_output("k1_ad_a", 64'(ad_a), 64'd0);
        check_output("k1_valid", 64'(valid), 64'd0);
        wait_valid("ripple_latency");
        check_output("ripple_res", 64'(res), 64'h400);
        check_output("ripple_carry", 64'(carry_out), 64'd0);
        check_output("done_ad_quiet", {ad_a, ad_b, ad_cin}, 64'd0);
        do_ack();
        check_output("ack_valid", 64'(valid), 64'd0);
        check_output("ack_ready", 64'(ready), 64'd1);
        check_output("ack_res_kept", 64'(res), 64'h400);

        // All ones plus carry-in, with a stray start during RUN and start+ack in DONE
        apply_stimulus(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, 1'b0);
        a     = 40'h1;
        b     = 40'h1;
        start = 1'b1;
        @(negedge clk);
        n++;
        start = 1'b0;
        wait_valid("ones_latency");
        check_output("ones_res", 64'(res), 64'hFF_FFFF_FFFF);
        check_output("ones_carry", 64'(carry_out), 64'd1);
        @(negedge clk);
        check_output("hold_valid1", 64'(valid), 64'd1);
        @(negedge clk);
        check_output("hold_valid2", 64'(valid), 64'd1);
        check_output("hold_res", 64'(res), 64'hFF_FFFF_FFFF);
        check_output("done_ready", 64'(ready), 64'd0);
        ack   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        check_output("start_ack_valid", 64'(valid), 64'd0);
        check_output("start_ack_ready", 64'(ready), 64'd1);
        repeat (6) @(negedge clk);
        check_output("no_queue_valid", 64'(valid), 64'd0);
        check_output("no_queue_ready", 64'(ready), 64'd1);
        check_output("no_queue_res", 64'(res), 64'hFF_FFFF_FFFF);

        // Reset during RUN chunk 2
        apply_stimulus(40'hFF_FFFF_FFFF, 40'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_output("k2_ad_a", 64'(ad_a), 64'h3FF);
        rst_n = 1'b0;
        #1;
        check_output("abort_ready", 64'(ready), 64'd1);
        check_output("abort_valid", 64'(valid), 64'd0);
        check_output("abort_res", 64'(res), 64'd0);
        check_output("abort_carry", 64'(carry_out), 64'd0);
        check_output("abort_ad", {ad_a, ad_b, ad_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(40'd5, 40'd7, 1'b0, 1'b0);
        wait_valid("post_reset_latency");
        check_output("post_reset_res", 64'(res), 64'd12);
        check_output("post_reset_carry", 64'(carry_out), 64'd0);
        do_ack();

        // MSB chunk carry-out with zero result
        apply_stimulus(40'h80_0000_0000, 40'h80_0000_0000, 1'b0, 1'b0);
        wait_valid("msb_latency");
        check_output("msb_res", 64'(res), 64'd0);
        check_output("msb_carry", 64'(carry_out), 64'd1);
        do_ack();

`ifdef CHUNK_ADD_SUB_EN
        apply_stimulus(40'd5, 40'd7, 1'b0, 1'b1);
        wait_valid("sub_neg_latency");
        check_output("sub_neg_res", 64'(res), 64'hFF_FFFF_FFFE);
        check_output("sub_neg_carry", 64'(carry_out), 64'd0);
        do_ack();
        apply_stimulus(40'd7, 40'd5, 1'b0, 1'b1);
        wait_valid("sub_pos_latency");
        check_output("sub_pos_res", 64'(res), 64'd2);
        check_output("sub_pos_carry", 64'(carry_out), 64'd1);
        do_ack();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
